vidmem_tgt: RTL and testbench
=============================

# vidmem_tgt

Bus target that answers the video controller's fetch traffic: it services READ bursts from a word-addressed frame-buffer memory, and accepts WRITE bursts so a bench or CPU model can preload pixels. It sits on the same shared command/address-data bus as the video controller, at the far end of its `rgb_fetch` read requests. It bids for the bus through the arbiter (`reqout`/`ackin`) to return read data and write responses.

## Interface
- `DEPTH_LOG2`, 10: memory depth is 2^DEPTH_LOG2 32-bit words.
- `BASE`, 32'h0010_0000: decode base; must be aligned to 4·2^DEPTH_LOG2.
- `RESP_TAR`, 4'h1: value driven on `reqtar` during responses.
- `RESP_PRI`, 2'b01: value driven on `reqout` while bidding or transferring.
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `selin` in 1: bus cycle is addressed to this target.
- `cmdin` in 3: command.
- `lenin` in 2: burst length code, beats = 1<<lenin (1/2/4/8).
- `addrdatain` in 32: byte address on request cycle, data on write beats.
- `ackin` in 1: arbiter grant.
- `reqout` out 2: bid/priority, nonzero = bus owned or requested.
- `lenout` out 2: echoed length code on response header.
- `addrdataout` out 32: address on header, data on beats.
- `cmdout` out 3: response command.
- `reqtar` out 4: destination of response.

## Operation
- Commands: 000 DATA/idle, 010 READ, 011 READ_RESP, 100 WRITE, 101 WRITE_RESP, 111 ERR_RESP.
- Hit: `selin`=1 and addrdatain[31:DEPTH_LOG2+2] == BASE[31:DEPTH_LOG2+2]. Word index = addr[DEPTH_LOG2+1:2]; addr[1:0] ignored.
- States: IDLE, WR_DATA, RD_BID, RD_HDR, RD_DATA, WR_BID, WR_RESP.
- IDLE: on READ hit, latch addr/len, go RD_BID. On WRITE hit, latch addr/len and go WR_DATA. Other commands and misses are ignored.
- WR_DATA: every cycle with `selin`=1 and `cmdin`=000 writes addrdatain to mem[(idx+k) mod depth], k=0..beats-1. Cycles with `selin`=0 stall without writing. After the last beat go WR_BID.
- RD_BID/WR_BID: `reqout`=RESP_PRI, `reqtar`=RESP_TAR. On `ackin`=1, go RD_HDR or WR_RESP.
- RD_HDR: one cycle with `cmdout`=011, `lenout`=len, `addrdataout`=latched byte address, then RD_DATA.
- RD_DATA: beats cycles with `cmdout`=000 and `addrdataout`=mem[(idx+k) mod depth]. No stalls. Return to IDLE after the last beat.
- WR_RESP: one cycle with `cmdout`=101, `addrdataout`=latched address, `lenout`=len, then IDLE.
- `reqout`/`reqtar` stay asserted from the bid through the final response cycle. All outputs are 0 in IDLE and WR_DATA.
- Requests arriving in any non-IDLE state are dropped. No queueing.
- Burst index wraps modulo depth. It does not cross into the next decode window.

## Timing
- Reset: next edge forces IDLE, all outputs 0, latched addr/len cleared. Memory contents are not reset. Reset mid-burst abandons the transfer with no response.
- Read, `ackin` already high: request at cycle 0, bid at cycle 1, header at cycle 2, data beats at cycles 3..2+beats.
- `ackin` low extends RD_BID/WR_BID indefinitely. Once granted, the transfer is not interruptible by `ackin` dropping.
- Write beat k is visible to a read whose header issues at least 1 cycle after the write's WR_RESP.
- Memory is synchronous-read. The implementation prefetches so beats are back-to-back with no bubble after the header.

## Configuration
- `VIDMEM_TGT_ERR_EN` defined: a selected READ/WRITE miss, or a selected cmd not in {010,100} while IDLE, triggers a bid. After grant there is one cycle with `cmdout`=111 and `addrdataout`=offending address. For a WRITE miss, the data beats are still consumed (discarded) before the bid.
- Not defined: all such cycles are silently ignored, and the ERR states and logic are absent.

## Structure
- `vidbus_pkg`: command encoding enum (shared with the video controller), `beats_from_len()` function, state enum.
- Sub-module `vidmem_ram`: single-port synchronous RAM, parameter DEPTH_LOG2, one write or read per cycle.
- `vidmem_tgt`: decode, FSM, beat counter (4 bits), address incrementer, arbiter handshake.

## Test plan
- Reset: drive `reset` for 2 cycles mid-read → all outputs 0 the next cycle, no further response. Memory keeps prior contents.
- Write then read: WRITE len=2 to 0x0010_0010 with data 0xA0..0xA3, WRITE_RESP after grant. Then READ len=2 at the same address → header 011/0x0010_0010, beats 0xA0,0xA1,0xA2,0xA3 on consecutive cycles.
- Grant delay: READ len=0 with `ackin` held low 5 cycles → `reqout`=01 for 5 cycles. The header appears the cycle after `ackin` rises.
- Wrap: WRITE len=3 at word index 1022 → words 1022,1023,0..5 written. READ back at index 1022 returns the same order.
- Busy drop: a second READ issued during RD_DATA → ignored, exactly one response burst.
- Miss: READ to 0x0020_0000 → no bid. With `VIDMEM_TGT_ERR_EN`, ERR_RESP 111 with address 0x0020_0000.

Source files
------------

// File: rtl/vidbus_pkg.sv
// ============================================================================
//  Module      : vidbus_pkg
//  Description : Shared video-bus command encoding, target FSM states and
//                burst-length helper. Optional macro: VIDMEM_TGT_ERR_EN.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package vidbus_pkg;

    typedef enum logic [2:0] {
        CMD_DATA       = 3'b000,
        CMD_READ       = 3'b010,
        CMD_READ_RESP  = 3'b011,
        CMD_WRITE      = 3'b100,
        CMD_WRITE_RESP = 3'b101,
        CMD_ERR_RESP   = 3'b111
    } vidbus_cmd_e;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WR_DATA   = 4'd1,
        ST_RD_BID    = 4'd2,
        ST_RD_HDR    = 4'd3,
        ST_RD_DATA   = 4'd4,
        ST_WR_BID    = 4'd5,
        ST_WR_RESP   = 4'd6
`ifdef VIDMEM_TGT_ERR_EN
        ,
        ST_ERR_DRAIN = 4'd7,
        ST_ERR_BID   = 4'd8,
        ST_ERR_RESP  = 4'd9
`endif
    } vidmem_state_e;

    function automatic logic [3:0] beats_from_len(input logic [1:0] len);
        return 4'd1 << len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vidmem_ram.sv
// ============================================================================
//  Module      : vidmem_ram
//  Description : Single-port synchronous frame-buffer RAM, one access per cycle.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module vidmem_ram
    import vidbus_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [0:(1<<DEPTH_LOG2)-1];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/vidmem_tgt.sv
// ============================================================================
//  Module      : vidmem_tgt
//  Description : Frame-buffer bus target serving READ/WRITE bursts with
//                arbitrated responses. Optional macro: VIDMEM_TGT_ERR_EN.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module vidmem_tgt
    import vidbus_pkg::*;
#(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [31:0] BASE       = 32'h0010_0000,
    parameter logic [3:0]  RESP_TAR   = 4'h1,
    parameter logic [1:0]  RESP_PRI   = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        selin,
    input  logic [2:0]  cmdin,
    input  logic [1:0]  lenin,
    input  logic [31:0] addrdatain,
    input  logic        ackin,
    output logic [1:0]  reqout,
    output logic [1:0]  lenout,
    output logic [31:0] addrdataout,
    output logic [2:0]  cmdout,
    output logic [3:0]  reqtar
);

    vidmem_state_e         state_q;
    logic [31:0]           addr_q;
    logic [1:0]            len_q;
    logic [DEPTH_LOG2-1:0] ptr_q;
    logic [3:0]            cnt_q;
    logic [1:0]            reqout_q;
    logic [3:0]            reqtar_q;
    vidbus_cmd_e           cmdout_q;
    logic [1:0]            lenout_q;
    logic [31:0]           addrdata_q;
    logic                  rdsel_q;

    logic                  w_hit;
    logic                  w_last;
    logic                  w_data_beat;
    logic                  w_ram_we;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic [31:0]           w_ram_rdata;

    assign w_idx       = addrdatain[DEPTH_LOG2+1:2];
    assign w_hit       = selin && (addrdatain[31:DEPTH_LOG2+2] == BASE[31:DEPTH_LOG2+2]);
    assign w_last      = (cnt_q == beats_from_len(len_q) - 4'd1);
    assign w_data_beat = selin && (cmdin == CMD_DATA);
    assign w_ram_we    = (state_q == ST_WR_DATA) && w_data_beat;

    // The RAM address is always the burst pointer: it advances on each write
    // beat, and on reads it runs one word ahead of the beat being presented.
    vidmem_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .we_i    (w_ram_we),
        .addr_i  (ptr_q),
        .wdata_i (addrdatain),
        .rdata_o (w_ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            reqout_q   <= '0;
            reqtar_q   <= '0;
            cmdout_q   <= CMD_DATA;
            lenout_q   <= '0;
            addrdata_q <= '0;
            rdsel_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_hit && (cmdin == CMD_READ)) begin
                        addr_q   <= addrdatain;
                        len_q    <= lenin;
                        ptr_q    <= w_idx;
                        cnt_q    <= '0;
                        reqout_q <= RESP_PRI;
                        reqtar_q <= RESP_TAR;
                        state_q  <= ST_RD_BID;
                    end else if (w_hit && (cmdin == CMD_WRITE)) begin
                        addr_q  <= addrdatain;
                        len_q   <= lenin;
                        ptr_q   <= w_idx;
                        cnt_q   <= '0;
                        state_q <= ST_WR_DATA;
                    end
`ifdef VIDMEM_TGT_ERR_EN
                    else if (selin) begin
                        addr_q <= addrdatain;
                        len_q  <= lenin;
                        cnt_q  <= '0;
                        if (cmdin == CMD_WRITE) begin
                            state_q <= ST_ERR_DRAIN;
                        end else begin
                            reqout_q <= RESP_PRI;
                            reqtar_q <= RESP_TAR;
                            state_q  <= ST_ERR_BID;
                        end
                    end
`endif
                end
                ST_WR_DATA: begin
                    if (w_data_beat) begin
                        ptr_q <= ptr_q + DEPTH_LOG2'(1);
                        cnt_q <= cnt_q + 4'd1;
                        if (w_last) begin
                            reqout_q <= RESP_PRI;
                            reqtar_q <= RESP_TAR;
                            state_q  <= ST_WR_BID;
                        end
                    end
                end
                ST_RD_BID: begin
                    if (ackin) begin
                        cmdout_q   <= CMD_READ_RESP;
                        lenout_q   <= len_q;
                        addrdata_q <= addr_q;
                        state_q    <= ST_RD_HDR;
                    end
                end
                ST_RD_HDR: begin
                    ptr_q      <= ptr_q + DEPTH_LOG2'(1);
                    cnt_q      <= '0;
                    cmdout_q   <= CMD_DATA;
                    lenout_q   <= '0;
                    addrdata_q <= '0;
                    rdsel_q    <= 1'b1;
                    state_q    <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    ptr_q <= ptr_q + DEPTH_LOG2'(1);
                    cnt_q <= cnt_q + 4'd1;
                    if (w_last) begin
                        reqout_q <= '0;
                        reqtar_q <= '0;
                        rdsel_q  <= 1'b0;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_WR_BID: begin
                    if (ackin) begin
                        cmdout_q   <= CMD_WRITE_RESP;
                        lenout_q   <= len_q;
                        addrdata_q <= addr_q;
                        state_q    <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    reqout_q   <= '0;
                    reqtar_q   <= '0;
                    cmdout_q   <= CMD_DATA;
                    lenout_q   <= '0;
                    addrdata_q <= '0;
                    state_q    <= ST_IDLE;
                end
`ifdef VIDMEM_TGT_ERR_EN
                ST_ERR_DRAIN: begin
                    if (w_data_beat) begin
                        cnt_q <= cnt_q + 4'd1;
                        if (w_last) begin
                            reqout_q <= RESP_PRI;
                            reqtar_q <= RESP_TAR;
                            state_q  <= ST_ERR_BID;
                        end
                    end
                end
                ST_ERR_BID: begin
                    if (ackin) begin
                        cmdout_q   <= CMD_ERR_RESP;
                        lenout_q   <= len_q;
                        addrdata_q <= addr_q;
                        state_q    <= ST_ERR_RESP;
                    end
                end
                ST_ERR_RESP: begin
                    reqout_q   <= '0;
                    reqtar_q   <= '0;
                    cmdout_q   <= CMD_DATA;
                    lenout_q   <= '0;
                    addrdata_q <= '0;
                    state_q    <= ST_IDLE;
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign reqout      = reqout_q;
    assign reqtar      = reqtar_q;
    assign cmdout      = cmdout_q;
    assign lenout      = lenout_q;
    assign addrdataout = rdsel_q ? w_ram_rdata : addrdata_q;

endmodule

`default_nettype wire

// File: tb/tb_vidmem_tgt.sv
// ============================================================================
//  Module      : tb_vidmem_tgt
//  Description : Directed self-checking bench for vidmem_tgt.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_vidmem_tgt;

    logic        clk = 1'b0;
    logic        reset;
    logic        selin;
    logic [2:0]  cmdin;
    logic [1:0]  lenin;
    logic [31:0] addrdatain;
    logic        ackin;
    logic [1:0]  reqout;
    logic [1:0]  lenout;
    logic [31:0] addrdataout;
    logic [2:0]  cmdout;
    logic [3:0]  reqtar;

    int n_vec = 0;
    int n_err = 0;

    vidmem_tgt u_dut (
        .clk         (clk),
        .reset       (reset),
        .selin       (selin),
        .cmdin       (cmdin),
        .lenin       (lenin),
        .addrdatain  (addrdatain),
        .ackin       (ackin),
        .reqout      (reqout),
        .lenout      (lenout),
        .addrdataout (addrdataout),
        .cmdout      (cmdout),
        .reqtar      (reqtar)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle;
        selin      = 1'b0;
        cmdin      = 3'b000;
        lenin      = 2'd0;
        addrdatain = 32'h0;
    endtask

    task automatic drive_req(input logic [2:0] cmd, input logic [31:0] addr, input logic [1:0] len);
        selin      = 1'b1;
        cmdin      = cmd;
        lenin      = len;
        addrdatain = addr;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_req"}, 32'(reqout), 32'h0);
        check_eq({tag, "_cmd"}, 32'(cmdout), 32'h0);
        check_eq({tag, "_tar"}, 32'(reqtar), 32'h0);
        check_eq({tag, "_len"}, 32'(lenout), 32'h0);
        check_eq({tag, "_ad"},  addrdataout, 32'h0);
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [1:0] len,
                               input logic [31:0] d0, input int stall_at);
        int beats;
        beats = 1 << len;
        ackin = 1'b1;
        drive_req(3'b100, addr, len);
        tick;
        check_eq("wr_data_req", 32'(reqout), 32'h0);
        for (int k = 0; k < beats; k++) begin
            if (k == stall_at) begin
                bus_idle();
                tick;
                check_eq("wr_stall_req", 32'(reqout), 32'h0);
            end
            selin      = 1'b1;
            cmdin      = 3'b000;
            addrdatain = d0 + 32'(k);
            tick;
        end
        bus_idle();
        check_eq("wr_bid_req", 32'(reqout), 32'h1);
        check_eq("wr_bid_tar", 32'(reqtar), 32'h1);
        tick;
        check_eq("wr_resp_cmd", 32'(cmdout), 32'h5);
        check_eq("wr_resp_addr", addrdataout, addr);
        check_eq("wr_resp_len", 32'(lenout), 32'(len));
        check_eq("wr_resp_req", 32'(reqout), 32'h1);
        tick;
        check_eq("wr_done_req", 32'(reqout), 32'h0);
        check_eq("wr_done_cmd", 32'(cmdout), 32'h0);
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [1:0] len,
                              input logic [31:0] d0, input int ack_delay, input int busy_at);
        int beats;
        beats = 1 << len;
        ackin = (ack_delay == 0);
        drive_req(3'b010, addr, len);
        tick;
        bus_idle();
        for (int i = 0; i < ack_delay; i++) begin
            check_eq("rd_wait_req", 32'(reqout), 32'h1);
            check_eq("rd_wait_cmd", 32'(cmdout), 32'h0);
            tick;
        end
        ackin = 1'b1;
        check_eq("rd_bid_req", 32'(reqout), 32'h1);
        check_eq("rd_bid_tar", 32'(reqtar), 32'h1);
        tick;
        check_eq("rd_hdr_cmd", 32'(cmdout), 32'h3);
        check_eq("rd_hdr_len", 32'(lenout), 32'(len));
        check_eq("rd_hdr_addr", addrdataout, addr);
        tick;
        for (int k = 0; k < beats; k++) begin
            check_eq("rd_beat_cmd", 32'(cmdout), 32'h0);
            check_eq("rd_beat_data", addrdataout, d0 + 32'(k));
            check_eq("rd_beat_req", 32'(reqout), 32'h1);
            if (k == busy_at) drive_req(3'b010, addr, len);
            tick;
            bus_idle();
        end
        check_eq("rd_end_req", 32'(reqout), 32'h0);
        check_eq("rd_end_cmd", 32'(cmdout), 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        ackin = 1'b1;
        bus_idle();
        tick;
        tick;
        check_quiet("reset");
        reset = 1'b0;
        tick;
        check_quiet("idle");

        // Write 0xA0..0xA3 to words 4..7, then read them back.
        write_burst(32'h0010_0010, 2'd2, 32'hA0, -1);
        read_burst(32'h0010_0010, 2'd2, 32'hA0, 0, -1);

        // Grant held off for 5 bid cycles.
        read_burst(32'h0010_0010, 2'd0, 32'hA0, 5, -1);

        // Second READ during RD_DATA must be dropped.
        read_burst(32'h0010_0014, 2'd1, 32'hA1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            tick;
            check_eq("busy_no_resp", 32'(reqout), 32'h0);
        end

        // Reset during a read burst abandons it.
        drive_req(3'b010, 32'h0010_0010, 2'd3);
        tick;
        bus_idle();
        tick;
        tick;
        check_eq("rst_beat0", addrdataout, 32'hA0);
        reset = 1'b1;
        tick;
        check_quiet("rst_mid");
        tick;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            check_eq("rst_no_resp", 32'(reqout), 32'h0);
        end
        read_burst(32'h0010_0014, 2'd0, 32'hA1, 0, -1);

        // Decode miss.
        drive_req(3'b010, 32'h0020_0000, 2'd0);
        tick;
        bus_idle();
`ifdef VIDMEM_TGT_ERR_EN
        check_eq("err_bid_req", 32'(reqout), 32'h1);
        tick;
        check_eq("err_resp_cmd", 32'(cmdout), 32'h7);
        check_eq("err_resp_addr", addrdataout, 32'h0020_0000);
        tick;
        check_eq("err_done_req", 32'(reqout), 32'h0);
`else
        for (int i = 0; i < 3; i++) begin
            check_eq("miss_no_bid", 32'(reqout), 32'h0);
            tick;
        end
`endif

        // Wrap: words 1022,1023,0..5 get 0xC0..0xC7, with one stall cycle.
        write_burst(32'h0010_0FF8, 2'd3, 32'hC0, 3);
        read_burst(32'h0010_0FF8, 2'd3, 32'hC0, 0, -1);
        read_burst(32'h0010_0000, 2'd1, 32'hC2, 0, -1);
        read_burst(32'h0010_0018, 2'd1, 32'hA2, 0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
